// File: rtl/rx_cic_ctrl.sv
// Rate-change and I/Q pairing controller wrapped around a CIC decimator.
// Define RX_CIC_ERR_CNT_EN to add the saturating err_cnt output.
module rx_cic_ctrl #(
   parameter int DEFAULT_RATE = 160,
   parameter int MIN_RATE     = 8,
   parameter int FLUSH_CYCLES = 8,
   parameter int SETTLE_PAIRS = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [9:0]  rate_req,
   input  logic        rate_req_valid,
   output logic        rate_busy,
   input  logic        s_valid,
   output logic        s_ready,
   input  logic [26:0] s_i,
   input  logic [26:0] s_q,
   output logic        cic_in_valid,
   input  logic        cic_in_ready,
   output logic [26:0] cic_in0,
   output logic [26:0] cic_in1,
   output logic [1:0]  cic_in_error,
   output logic [9:0]  cic_rate,
   output logic        cic_reset_n,
   output logic        cic_clken,
   input  logic [31:0] cic_out_data,
   input  logic        cic_out_valid,
   output logic        cic_out_ready,
   input  logic        cic_out_channel,
   input  logic [1:0]  cic_out_error,
   output logic        m_valid,
   input  logic        m_ready,
   output logic [31:0] m_i,
   output logic [31:0] m_q,
   output logic        sync_err
`ifdef RX_CIC_ERR_CNT_EN
   ,
   output logic [15:0] err_cnt
`endif
);

   typedef enum logic [1:0] {RUN, DRAIN, FLUSH, SETTLE} state_t;

   localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
   localparam int SW = $clog2(SETTLE_PAIRS + 1);

   state_t          state_q, state_d;
   logic [FW-1:0]   flushCnt_q, flushCnt_d;
   logic [SW-1:0]   settleCnt_q, settleCnt_d;
   logic [9:0]      rate_q, rate_d;
   logic            pendValid_q, pendValid_d;
   logic [9:0]      pend_q, pend_d;
   logic            heldValid_q, heldValid_d;
   logic [31:0]     heldI_q, heldI_d;
   logic            mValid_q, mValid_d;
   logic [31:0]     mI_q, mI_d;
   logic [31:0]     mQ_q, mQ_d;
   logic            syncErr_q, syncErr_d;

   logic passThru, outReady, accept, gotI, gotQ, pairFormed, orphanQ, flushEntry;

   assign passThru   = (state_q == RUN) || (state_q == SETTLE);
   assign outReady   = !mValid_q || m_ready;
   assign accept     = cic_out_valid && outReady;
   assign gotI       = accept && !cic_out_channel;
   assign gotQ       = accept && cic_out_channel;
   assign pairFormed = gotQ && heldValid_q;
   assign orphanQ    = gotQ && !heldValid_q;
   assign flushEntry = (state_q == DRAIN) && !mValid_q;

   assign s_ready       = passThru ? cic_in_ready : 1'b0;
   assign cic_in_valid  = passThru ? s_valid : 1'b0;
   assign cic_in0       = s_i;
   assign cic_in1       = s_q;
   assign cic_in_error  = 2'b00;
   assign cic_rate      = rate_q;
   assign cic_reset_n   = (state_q != FLUSH);
   assign cic_clken     = 1'b1;
   assign cic_out_ready = outReady;
   assign m_valid       = mValid_q;
   assign m_i           = mI_q;
   assign m_q           = mQ_q;
   assign sync_err      = syncErr_q;
   assign rate_busy     = (state_q != RUN) || pendValid_q;

   always_comb begin
      state_d     = state_q;
      flushCnt_d  = flushCnt_q;
      settleCnt_d = settleCnt_q;
      case (state_q)
         RUN: begin
            if (pendValid_q) state_d = DRAIN;
         end
         DRAIN: begin
            if (!mValid_q) begin
               state_d    = FLUSH;
               flushCnt_d = '0;
            end
         end
         FLUSH: begin
            if (flushCnt_q == FW'(FLUSH_CYCLES - 1)) begin
               state_d     = SETTLE;
               settleCnt_d = SW'(SETTLE_PAIRS);
            end else begin
               flushCnt_d = flushCnt_q + FW'(1);
            end
         end
         SETTLE: begin
            if (pairFormed) begin
               if (settleCnt_q <= SW'(1)) state_d = RUN;
               else settleCnt_d = settleCnt_q - SW'(1);
            end
         end
         default: state_d = FLUSH;
      endcase
   end

   // A strobe in the same cycle as the flush entry is a fresh request and must survive the clear.
   always_comb begin
      rate_d      = rate_q;
      pendValid_d = pendValid_q;
      pend_d      = pend_q;
      heldValid_d = heldValid_q;
      heldI_d     = heldI_q;
      mValid_d    = mValid_q;
      mI_d        = mI_q;
      mQ_d        = mQ_q;
      syncErr_d   = syncErr_q || orphanQ;
      if (flushEntry)
         rate_d = (pend_q < 10'(MIN_RATE)) ? 10'(MIN_RATE) : pend_q;
      if (rate_req_valid) begin
         pendValid_d = 1'b1;
         pend_d      = rate_req;
      end else if (flushEntry) begin
         pendValid_d = 1'b0;
      end
      if (flushEntry) begin
         heldValid_d = 1'b0;
         heldI_d     = '0;
      end else if (gotI) begin
         heldValid_d = 1'b1;
         heldI_d     = cic_out_data;
      end else if (pairFormed) begin
         heldValid_d = 1'b0;
      end
      if (pairFormed && (state_q == RUN)) begin
         mValid_d = 1'b1;
         mI_d     = heldI_q;
         mQ_d     = cic_out_data;
      end else if (mValid_q && m_ready) begin
         mValid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= FLUSH;
         flushCnt_q  <= '0;
         settleCnt_q <= '0;
         rate_q      <= 10'(DEFAULT_RATE);
         pendValid_q <= 1'b0;
         pend_q      <= '0;
         heldValid_q <= 1'b0;
         heldI_q     <= '0;
         mValid_q    <= 1'b0;
         mI_q        <= '0;
         mQ_q        <= '0;
         syncErr_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         flushCnt_q  <= flushCnt_d;
         settleCnt_q <= settleCnt_d;
         rate_q      <= rate_d;
         pendValid_q <= pendValid_d;
         pend_q      <= pend_d;
         heldValid_q <= heldValid_d;
         heldI_q     <= heldI_d;
         mValid_q    <= mValid_d;
         mI_q        <= mI_d;
         mQ_q        <= mQ_d;
         syncErr_q   <= syncErr_d;
      end
   end

`ifdef RX_CIC_ERR_CNT_EN
   logic [15:0] errCnt_q, errCnt_d;

   always_comb begin
      errCnt_d = errCnt_q;
      if (accept && (cic_out_error != 2'b00) && (errCnt_q != 16'hFFFF))
         errCnt_d = errCnt_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) errCnt_q <= '0;
      else       errCnt_q <= errCnt_d;
   end

   assign err_cnt = errCnt_q;
`else
   logic unusedErr;
   assign unusedErr = ^cic_out_error;
`endif

endmodule

// File: tb/tb_rx_cic_ctrl.sv
// Directed self-checking bench for rx_cic_ctrl; err_cnt checks run only with RX_CIC_ERR_CNT_EN.
module tb_rx_cic_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  rate_req;
   logic        rate_req_valid;
   logic        rate_busy;
   logic        s_valid;
   logic        s_ready;
   logic [26:0] s_i, s_q;
   logic        cic_in_valid;
   logic        cic_in_ready;
   logic [26:0] cic_in0, cic_in1;
   logic [1:0]  cic_in_error;
   logic [9:0]  cic_rate;
   logic        cic_reset_n;
   logic        cic_clken;
   logic [31:0] cic_out_data;
   logic        cic_out_valid;
   logic        cic_out_ready;
   logic        cic_out_channel;
   logic [1:0]  cic_out_error;
   logic        m_valid;
   logic        m_ready;
   logic [31:0] m_i, m_q;
   logic        sync_err;
`ifdef RX_CIC_ERR_CNT_EN
   logic [15:0] err_cnt;
`endif

   int total = 0;
   int bad   = 0;

   rx_cic_ctrl dut (
      .clk(clk), .reset(reset),
      .rate_req(rate_req), .rate_req_valid(rate_req_valid), .rate_busy(rate_busy),
      .s_valid(s_valid), .s_ready(s_ready), .s_i(s_i), .s_q(s_q),
      .cic_in_valid(cic_in_valid), .cic_in_ready(cic_in_ready),
      .cic_in0(cic_in0), .cic_in1(cic_in1), .cic_in_error(cic_in_error),
      .cic_rate(cic_rate), .cic_reset_n(cic_reset_n), .cic_clken(cic_clken),
      .cic_out_data(cic_out_data), .cic_out_valid(cic_out_valid),
      .cic_out_ready(cic_out_ready), .cic_out_channel(cic_out_channel),
      .cic_out_error(cic_out_error),
      .m_valid(m_valid), .m_ready(m_ready), .m_i(m_i), .m_q(m_q),
      .sync_err(sync_err)
`ifdef RX_CIC_ERR_CNT_EN
      , .err_cnt(err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input logic ch, input logic [31:0] data, input logic [1:0] err);
      cic_out_channel = ch;
      cic_out_data    = data;
      cic_out_error   = err;
      cic_out_valid   = 1'b1;
      tick();
      cic_out_valid   = 1'b0;
      cic_out_error   = 2'b00;
   endtask

   task automatic sendPair(input logic [31:0] i, input logic [31:0] q);
      applyStimulus(1'b0, i, 2'b00);
      applyStimulus(1'b1, q, 2'b00);
   endtask

   task automatic strobeRate(input logic [9:0] r);
      rate_req       = r;
      rate_req_valid = 1'b1;
      tick();
      rate_req_valid = 1'b0;
   endtask

   // Counts cycles while cic_reset_n stays low; also flags any s_ready seen during that window.
   task automatic countFlush(input string tag, input int expCycles);
      int n = 0;
      logic sawReady = 1'b0;
      while (!cic_reset_n && n < 200) begin
         if (s_ready) sawReady = 1'b1;
         n++;
         tick();
      end
      checkOutput({tag, "_len"}, 32'(n), 32'(expCycles));
      checkOutput({tag, "_sready"}, {31'd0, sawReady}, 32'd0);
   endtask

   task automatic settle(input string tag);
      logic sawValid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         sendPair(32'h1000 + 32'(k), 32'h2000 + 32'(k));
         if (m_valid) sawValid = 1'b1;
      end
      checkOutput({tag, "_no_mvalid"}, {31'd0, sawValid}, 32'd0);
   endtask

   initial begin
      logic sawBad;
      int   n;
      reset = 1'b1; rate_req = '0; rate_req_valid = 1'b0;
      s_valid = 1'b0; s_i = '0; s_q = '0; cic_in_ready = 1'b1;
      cic_out_data = '0; cic_out_valid = 1'b0; cic_out_channel = 1'b0;
      cic_out_error = 2'b00; m_ready = 1'b1;
      tick(); tick();

      checkOutput("rst_reset_n", {31'd0, cic_reset_n}, 32'd0);
      checkOutput("rst_rate", {22'd0, cic_rate}, 32'd160);
      checkOutput("rst_mvalid", {31'd0, m_valid}, 32'd0);
      checkOutput("rst_mi", m_i, 32'd0);
      checkOutput("rst_syncerr", {31'd0, sync_err}, 32'd0);
      checkOutput("rst_busy", {31'd0, rate_busy}, 32'd1);
      checkOutput("rst_clken", {31'd0, cic_clken}, 32'd1);
      checkOutput("rst_in_error", {30'd0, cic_in_error}, 32'd0);
`ifdef RX_CIC_ERR_CNT_EN
      checkOutput("rst_errcnt", {16'd0, err_cnt}, 32'd0);
`endif

      // Power-up sequence: full flush, four discarded pairs, then the fifth pair is output.
      reset = 1'b0;
      countFlush("boot_flush", 8);
      checkOutput("boot_busy_settle", {31'd0, rate_busy}, 32'd1);
      settle("boot_settle");
      checkOutput("boot_busy_run", {31'd0, rate_busy}, 32'd0);
      sendPair(32'h0000_0111, 32'h0000_0222);
      checkOutput("pair5_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("pair5_i", m_i, 32'h111);
      checkOutput("pair5_q", m_q, 32'h222);

      s_valid = 1'b1; s_i = 27'h123_4567; s_q = 27'h765_4321; #1;
      checkOutput("pass_sready", {31'd0, s_ready}, 32'd1);
      checkOutput("pass_valid", {31'd0, cic_in_valid}, 32'd1);
      checkOutput("pass_in0", {5'd0, cic_in0}, 32'h123_4567);
      checkOutput("pass_in1", {5'd0, cic_in1}, 32'h765_4321);
      cic_in_ready = 1'b0; #1;
      checkOutput("pass_notready", {31'd0, s_ready}, 32'd0);
      cic_in_ready = 1'b1;

      // Request below the minimum clamps to 8.
      strobeRate(10'd4);
      checkOutput("req4_busy", {31'd0, rate_busy}, 32'd1);
      tick();
      checkOutput("drain_sready", {31'd0, s_ready}, 32'd0);
      checkOutput("drain_invalid", {31'd0, cic_in_valid}, 32'd0);
      checkOutput("drain_reset_n", {31'd0, cic_reset_n}, 32'd1);
      tick();
      checkOutput("req4_rate", {22'd0, cic_rate}, 32'd8);
      countFlush("req4_flush", 8);
      settle("req4_settle");
      checkOutput("req4_idle", {31'd0, rate_busy}, 32'd0);
      checkOutput("req4_rate_kept", {22'd0, cic_rate}, 32'd8);

      // Back-pressured output holds DRAIN until the pair is taken.
      m_ready = 1'b0;
      sendPair(32'h0000_0AAA, 32'h0000_0BBB);
      checkOutput("bp_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("bp_outready", {31'd0, cic_out_ready}, 32'd0);
      strobeRate(10'd100);
      tick();
      applyStimulus(1'b0, 32'h0000_0CCC, 2'b00);
      tick();
      checkOutput("bp_still_drain", {31'd0, cic_reset_n}, 32'd1);
      checkOutput("bp_sready", {31'd0, s_ready}, 32'd0);
      checkOutput("bp_hold_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("bp_hold_i", m_i, 32'hAAA);
      checkOutput("bp_hold_q", m_q, 32'hBBB);
      m_ready = 1'b1;
      tick();
      checkOutput("bp_taken", {31'd0, m_valid}, 32'd0);
      checkOutput("bp_drain_last", {31'd0, cic_reset_n}, 32'd1);
      tick();
      checkOutput("req100_flush", {31'd0, cic_reset_n}, 32'd0);
      checkOutput("req100_rate", {22'd0, cic_rate}, 32'd100);

      // Two requests during FLUSH: only the last one is applied.
      strobeRate(10'd200);
      strobeRate(10'd300);
      countFlush("req100_rest", 6);
      settle("req100_settle");
      sawBad = 1'b0;
      n = 0;
      while (cic_reset_n && n < 50) begin
         if (m_valid || cic_rate == 10'd200 || !rate_busy) sawBad = 1'b1;
         n++;
         tick();
      end
      checkOutput("req300_no_run", {31'd0, sawBad}, 32'd0);
      checkOutput("req300_timeout", {31'd0, cic_reset_n}, 32'd0);
      checkOutput("req300_rate", {22'd0, cic_rate}, 32'd300);
      countFlush("req300_flush", 8);
      settle("req300_settle");
      checkOutput("req300_idle", {31'd0, rate_busy}, 32'd0);

      // Orphan Q sets the sticky error; the next good pair still comes through.
      applyStimulus(1'b1, 32'h0000_0005, 2'b00);
      checkOutput("orphan_syncerr", {31'd0, sync_err}, 32'd1);
      checkOutput("orphan_no_valid", {31'd0, m_valid}, 32'd0);
      sendPair(32'h0000_0123, 32'h0000_0456);
      checkOutput("after_orphan_valid", {31'd0, m_valid}, 32'd1);
      checkOutput("after_orphan_i", m_i, 32'h123);
      checkOutput("after_orphan_q", m_q, 32'h456);
      checkOutput("syncerr_sticky", {31'd0, sync_err}, 32'd1);

`ifdef RX_CIC_ERR_CNT_EN
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 32'h0000_0777, 2'b01);
      checkOutput("errcnt_three", {16'd0, err_cnt}, 32'd3);
`endif

      // Reset in the middle of a change discards the pending request.
      strobeRate(10'd50);
      tick();
      reset = 1'b1;
      tick(); tick();
      checkOutput("midrst_rate", {22'd0, cic_rate}, 32'd160);
      checkOutput("midrst_syncerr", {31'd0, sync_err}, 32'd0);
      checkOutput("midrst_mvalid", {31'd0, m_valid}, 32'd0);
      reset = 1'b0;
      countFlush("midrst_flush", 8);
      settle("midrst_settle");
      checkOutput("midrst_idle", {31'd0, rate_busy}, 32'd0);
      checkOutput("midrst_rate_kept", {22'd0, cic_rate}, 32'd160);
`ifdef RX_CIC_ERR_CNT_EN
      checkOutput("midrst_errcnt", {16'd0, err_cnt}, 32'd0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rx_cic_ctrl.md
RX_CIC_CTRL -- requirements
Module: rx_cic_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEFAULT_RATE, 160, decimation rate loaded at reset.
- MIN_RATE, 8, lowest accepted rate; smaller requests clamp to it.
- FLUSH_CYCLES, 8, cycles cic_reset_n is held low per flush.
- SETTLE_PAIRS, 4, I/Q pairs discarded after each flush.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
- clk  in  1  single clock.
- reset  in  1  synchronous, active-high reset.
- rate_req  in  10  requested decimation rate.
- rate_req_valid  in  1  one-cycle strobe for rate_req.
- rate_busy  out  1  high while a rate change is pending or in progress.
- s_valid / s_ready  in / out  1 / 1  upstream I/Q handshake.
- s_i, s_q  in  27 each  upstream mixer I and Q.
- cic_in_valid / cic_in_ready  out / in  1 / 1  CIC input handshake.
- cic_in0, cic_in1  out  27 each  I and Q to the CIC.
- cic_in_error  out  2  tied to 0.
- cic_rate  out  10  CIC rate.
- cic_reset_n  out  1  CIC reset, active-low.
- cic_clken  out  1  CIC clock enable.
- cic_out_data  in  32  CIC output sample.
- cic_out_valid / cic_out_ready  in / out  1 / 1  CIC output handshake.
- cic_out_channel  in  1  0 = I, 1 = Q.
- cic_out_error  in  2  CIC error code.
- m_valid / m_ready  out / in  1 / 1  downstream handshake.
- m_i, m_q  out  32 each  paired decimated output.
- sync_err  out  1  sticky flag for a Q sample arriving without a held I.

Function
REQ-003 The FSM SHALL have the states RUN, DRAIN, FLUSH and SETTLE.
REQ-004 In RUN and SETTLE: s_ready = cic_in_ready, cic_in_valid = s_valid, cic_in0 = s_i, cic_in1 = s_q (combinational pass-through).
REQ-005 In DRAIN and FLUSH: s_ready = 0 and cic_in_valid = 0.
REQ-006 A rate_req_valid strobe in any state SHALL latch rate_req into a single pending slot; a later strobe overwrites it.
REQ-007 In RUN with a request pending, the FSM SHALL go to DRAIN on the next cycle.
REQ-008 DRAIN SHALL go to FLUSH on the first cycle in which m_valid = 0.
REQ-009 On FLUSH entry, cic_rate SHALL load max(pending, MIN_RATE), the pending slot SHALL clear, and the held I SHALL clear.
REQ-010 FLUSH SHALL hold cic_reset_n = 0 for exactly FLUSH_CYCLES cycles, then go to SETTLE.
REQ-011 SETTLE SHALL discard the first SETTLE_PAIRS complete pairs, then go to RUN.
REQ-012 A request pending on SETTLE exit SHALL go straight from RUN to DRAIN, with no pairs emitted.
REQ-013 rate_busy SHALL be high when state != RUN or a request is pending.
REQ-014 cic_clken SHALL be 1 in every state.
REQ-015 cic_out_ready SHALL equal (!m_valid | m_ready).
REQ-016 An accepted channel-0 sample SHALL be stored as the held I; a second I overwrites it.
REQ-017 An accepted channel-1 sample with an I held SHALL form a pair and clear the held I.
REQ-018 In RUN, a formed pair SHALL load m_i/m_q and set m_valid on the next edge (1-cycle latency).
REQ-019 In SETTLE, a formed pair SHALL only decrement the settle counter.
REQ-020 A channel-1 sample with no I held SHALL be dropped and SHALL set sync_err.
REQ-021 m_valid SHALL clear on m_valid & m_ready unless a new pair loads in the same cycle.
REQ-022 m_i/m_q SHALL be stable while m_valid & !m_ready.
REQ-023 cic_out_error is not used for pairing; samples carrying an error are paired normally.

Reset
REQ-024 While reset is asserted, at each clk edge: state = FLUSH with counter = 0, cic_rate = DEFAULT_RATE, pending cleared, held I cleared, m_valid = 0, m_i = m_q = 0, sync_err = 0, cic_reset_n = 0.
REQ-025 Reset asserted mid-operation SHALL abort any change in progress, discard any pending request, and restart the reset-to-SETTLE sequence.
REQ-026 After reset deassertion, the block SHALL perform a full FLUSH then SETTLE before emitting the first pair.

Configuration
REQ-027 With RX_CIC_ERR_CNT_EN defined, an output err_cnt [15:0] SHALL increment, saturating at 0xFFFF, on each accepted CIC output with cic_out_error != 0; reset clears it.
REQ-028 Without RX_CIC_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent.

Verification
REQ-029 The bench SHALL cover these scenarios:
- Reset, then continuous I/Q at rate 160: cic_reset_n low for 8 cycles, 4 pairs discarded, the 5th pair appears on m_i/m_q; rate_busy low after SETTLE.
- rate_req = 4 in RUN: cic_rate becomes 8, exactly one FLUSH of 8 cycles, s_ready = 0 throughout DRAIN and FLUSH.
- Requests 200 then 300 during FLUSH: a single further change to 300, with no return to RUN between them.
- m_ready held low while a pair waits: cic_out_ready = 0, m_i/m_q stable, DRAIN does not exit.
- Q sample with no I held: sync_err = 1, no m_valid; the following I,Q pair is output correctly.
- Macro defined, 3 outputs with error = 2'b01: err_cnt = 3.
